// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

  localparam int unsigned DW    = 64;
  localparam int unsigned OFF_W = 3;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_RESP
  } state_e;

  // Number of bytes touched by an access of the given size code.
  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    logic [3:0] n;
    case (size)
      SZ_B:    n = 4'd1;
      SZ_H:    n = 4'd2;
      SZ_W:    n = 4'd4;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

  // An access is misaligned when the offset is not a multiple of its size.
  function automatic logic misaligned(input logic [1:0] size, input logic [OFF_W-1:0] off);
    logic m;
    case (size)
      SZ_B:    m = 1'b0;
      SZ_H:    m = off[0];
      SZ_W:    m = (off[1:0] != 2'b00);
      default: m = (off != 3'b000);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane logic: load extraction/extension and store merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [DW-1:0]    buffer_i,
  input  logic [DW-1:0]    wdata_i,
  input  logic [OFF_W-1:0] off_i,
  input  logic [1:0]       size_i,
  input  logic             unsigned_i,
  output logic [DW-1:0]    load_data_o,
  output logic [DW-1:0]    store_data_o
);

  logic [DW-1:0] shifted;
  logic [7:0]    byte_mask;
  logic [DW-1:0] bit_mask;
  logic [DW-1:0] wshift;

  // Shift the addressed lane down to bit 0 and extend to the full width.
  always_comb begin
    shifted     = buffer_i >> {off_i, 3'b000};
    load_data_o = shifted;
    case (size_i)
      SZ_B: load_data_o = unsigned_i ? {56'd0, shifted[7:0]}
                                     : {{56{shifted[7]}}, shifted[7:0]};
      SZ_H: load_data_o = unsigned_i ? {48'd0, shifted[15:0]}
                                     : {{48{shifted[15]}}, shifted[15:0]};
      SZ_W: load_data_o = unsigned_i ? {32'd0, shifted[31:0]}
                                     : {{32{shifted[31]}}, shifted[31:0]};
      default: load_data_o = shifted;
    endcase
  end

  // Replace only the addressed bytes of the old doubleword with store data.
  always_comb begin
    byte_mask = 8'(9'((9'd1 << size_bytes(size_i)) - 9'd1) << off_i);
    wshift    = wdata_i << {off_i, 3'b000};
    bit_mask  = '0;
    for (int i = 0; i < 8; i++) begin
      bit_mask[8*i +: 8] = {8{byte_mask[i]}};
    end
    store_data_o = (buffer_i & ~bit_mask) | (wshift & bit_mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit in front of a 64-bit, no-byte-enable data memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 48,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_misaligned,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic                write_q, write_d;
  logic                unsigned_q, unsigned_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   buffer_q, buffer_d;

  logic                req_ready_q, req_ready_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_misaligned_q, resp_misaligned_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;

  logic [DATA_W-1:0]   align_buffer_c;
  logic [DATA_W-1:0]   load_data_c;
  logic [DATA_W-1:0]   store_data_c;

  // In CAP the fresh memory word is used directly so results register on the CAP exit edge.
  assign align_buffer_c = (state_q == ST_CAP) ? mem_rdata : buffer_q;

  lsu_align u_align (
    .buffer_i     (align_buffer_c),
    .wdata_i      (wdata_q),
    .off_i        (addr_q[2:0]),
    .size_i       (size_q),
    .unsigned_i   (unsigned_q),
    .load_data_o  (load_data_c),
    .store_data_o (store_data_c)
  );

  // Next-state and registered-output values, computed from the state being entered.
  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    size_d            = size_q;
    write_d           = write_q;
    unsigned_d        = unsigned_q;
    wdata_d           = wdata_q;
    buffer_d          = buffer_q;
    mem_read_d        = 1'b0;
    mem_write_d       = 1'b0;
    mem_address_d     = '0;
    mem_wdata_d       = '0;
    resp_valid_d      = 1'b0;
    resp_misaligned_d = 1'b0;
    resp_rdata_d      = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d     = req_addr;
          size_d     = req_size;
          write_d    = req_write;
          unsigned_d = req_unsigned;
          wdata_d    = req_wdata;
          if (misaligned(req_size, req_addr[2:0])) begin
            state_d           = ST_RESP;
            resp_valid_d      = 1'b1;
            resp_misaligned_d = 1'b1;
          end else if (req_write && (req_size == SZ_D)) begin
            state_d       = ST_WR;
            mem_write_d   = 1'b1;
            mem_address_d = {req_addr[ADDR_W-1:3], 3'b000};
            mem_wdata_d   = req_wdata;
          end else begin
            state_d       = ST_RD;
            mem_read_d    = 1'b1;
            mem_address_d = {req_addr[ADDR_W-1:3], 3'b000};
          end
        end
      end
      ST_RD: begin
        state_d = ST_CAP;
      end
      ST_CAP: begin
        buffer_d = mem_rdata;
        if (write_q) begin
          state_d       = ST_WR;
          mem_write_d   = 1'b1;
          mem_address_d = {addr_q[ADDR_W-1:3], 3'b000};
          mem_wdata_d   = store_data_c;
        end else begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_data_c;
        end
      end
      ST_WR: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  // State, latched request and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= ST_IDLE;
      addr_q            <= '0;
      size_q            <= '0;
      write_q           <= 1'b0;
      unsigned_q        <= 1'b0;
      wdata_q           <= '0;
      buffer_q          <= '0;
      req_ready_q       <= 1'b0;
      mem_read_q        <= 1'b0;
      mem_write_q       <= 1'b0;
      mem_address_q     <= '0;
      mem_wdata_q       <= '0;
      resp_valid_q      <= 1'b0;
      resp_misaligned_q <= 1'b0;
      resp_rdata_q      <= '0;
    end else begin
      state_q           <= state_d;
      addr_q            <= addr_d;
      size_q            <= size_d;
      write_q           <= write_d;
      unsigned_q        <= unsigned_d;
      wdata_q           <= wdata_d;
      buffer_q          <= buffer_d;
      req_ready_q       <= req_ready_d;
      mem_read_q        <= mem_read_d;
      mem_write_q       <= mem_write_d;
      mem_address_q     <= mem_address_d;
      mem_wdata_q       <= mem_wdata_d;
      resp_valid_q      <= resp_valid_d;
      resp_misaligned_q <= resp_misaligned_d;
      resp_rdata_q      <= resp_rdata_d;
    end
  end

  assign req_ready       = req_ready_q;
  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_address     = mem_address_q;
  assign mem_wdata       = mem_wdata_q;
  assign resp_valid      = resp_valid_q;
  assign resp_misaligned = resp_misaligned_q;
  assign resp_rdata      = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural data_memory.
module tb_load_store_unit;

  localparam int unsigned AW = 48;
  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_unsigned = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_misaligned;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  typedef struct {
    logic [63:0] rdata;
    logic        mis;
    int          acc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [63:0] rdata;
    logic        mis;
    int          cyc;
  } got_t;

  exp_t exp_q[$];
  got_t got_q[$];

  logic [63:0] mem     [logic [44:0]];
  logic [63:0] ref_mem [logic [44:0]];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int n_rd = 0;
  int n_wr = 0;
  int n_both = 0;
  logic [47:0] last_rd_addr = '0;
  logic [47:0] last_wr_addr = '0;
  logic [63:0] last_wr_data = '0;

  load_store_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read data memory: read data appears the cycle after mem_read is sampled.
  always @(posedge clk) begin
    if (mem_read) mem_rdata <= mem.exists(mem_address[47:3]) ? mem[mem_address[47:3]] : 64'd0;
    if (mem_write) mem[mem_address[47:3]] = mem_wdata;
  end

  // Bus activity counters.
  always @(posedge clk) begin
    if (rst_n) begin
      if (mem_read) begin n_rd++; last_rd_addr = mem_address; end
      if (mem_write) begin n_wr++; last_wr_addr = mem_address; last_wr_data = mem_wdata; end
      if (mem_read && mem_write) n_both++;
    end
  end

  // Response collector.
  always @(negedge clk) begin
    if (rst_n && resp_valid) got_q.push_back('{resp_rdata, resp_misaligned, cyc});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [63:0] ref_rd(input logic [47:0] a);
    return ref_mem.exists(a[47:3]) ? ref_mem[a[47:3]] : 64'd0;
  endfunction

  function automatic bit exp_mis(input logic [1:0] sz, input logic [47:0] a);
    case (sz)
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      2'd2:    return a[1:0] != 2'b00;
      default: return a[2:0] != 3'b000;
    endcase
  endfunction

  function automatic logic [63:0] model_load(input logic [47:0] a, input logic [1:0] sz, input logic u);
    logic [63:0] d;
    logic [63:0] r;
    int n;
    int off;
    d = ref_rd(a);
    n = 1 << sz;
    off = int'(a[2:0]);
    r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = d[8*(off+i) +: 8];
    if (!u && n < 8 && r[8*n-1]) begin
      for (int i = n; i < 8; i++) r[8*i +: 8] = 8'hFF;
    end
    return r;
  endfunction

  function automatic void model_store(input logic [47:0] a, input logic [1:0] sz, input logic [63:0] wd);
    logic [63:0] d;
    int n;
    int off;
    d = ref_rd(a);
    n = 1 << sz;
    off = int'(a[2:0]);
    for (int i = 0; i < n; i++) d[8*(off+i) +: 8] = wd[8*i +: 8];
    ref_mem[a[47:3]] = d;
  endfunction

  // Present one request when the unit is ready; optionally record its expected response.
  task automatic send(input logic w, input logic [1:0] sz, input logic u, input logic [47:0] a,
                      input logic [63:0] wd, input bit push, input bit keep);
    bit ok;
    exp_t e;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_ready: req_ready=%b required 1 within 40 cycles", req_ready);
      req_valid = 1'b0;
      return;
    end
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = wd;
    @(posedge clk);
    #1;
    if (push) begin
      e.mis   = exp_mis(sz, a);
      e.lat   = e.mis ? 1 : (!w ? 3 : (sz == 2'd3 ? 2 : 4));
      e.rdata = (e.mis || w) ? 64'd0 : model_load(a, sz, u);
      e.acc   = cyc;
      exp_q.push_back(e);
      if (!e.mis && w) model_store(a, sz, wd);
    end
    if (!keep) req_valid = 1'b0;
    req_write    = 1'($urandom());
    req_size     = 2'($urandom());
    req_unsigned = 1'($urandom());
    req_addr     = 48'({$urandom(), $urandom()});
    req_wdata    = {$urandom(), $urandom()};
  endtask

  // Wait until every expected response has arrived (bounded).
  task automatic wait_drain();
    for (int k = 0; k < 80; k++) begin
      if (got_q.size() >= exp_q.size()) break;
      @(negedge clk);
    end
    if (got_q.size() < exp_q.size()) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d responses, required %0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: req_ready=%b required 0", req_ready);
    end
    n_checks++;
    if ({mem_read, mem_write, resp_valid, resp_misaligned} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: rd/wr/rv/mis=%b required 0000",
                         {mem_read, mem_write, resp_valid, resp_misaligned});
    end
    n_checks++;
    if (mem_address !== '0 || mem_wdata !== '0 || resp_rdata !== '0) begin
      n_fail++; $display("FAIL reset_data: addr=%h wdata=%h rdata=%h required 0",
                         mem_address, mem_wdata, resp_rdata);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_double_store_load();
    exp_t e;
    got_t g;
    int wr0;
    wr0 = n_wr;
    send(1'b1, 2'd3, 1'b0, 48'h10, 64'h1122334455667788, 1'b1, 1'b0);
    send(1'b0, 2'd3, 1'b0, 48'h10, 64'd0, 1'b1, 1'b0);
    wait_drain();
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g.rdata !== e.rdata || g.mis !== e.mis || (g.cyc - e.acc + 1) != e.lat) begin
        n_fail++;
        $display("FAIL dstore_load: rdata=%h mis=%b lat=%0d required rdata=%h mis=%b lat=%0d",
                 g.rdata, g.mis, g.cyc - e.acc + 1, e.rdata, e.mis, e.lat);
      end
    end
    n_checks++;
    if (n_wr - wr0 != 1 || last_wr_addr !== 48'h10) begin
      n_fail++; $display("FAIL dstore_write: writes=%0d addr=%h required 1 at 10", n_wr - wr0, last_wr_addr);
    end
  endtask

  task automatic test_byte_rmw();
    exp_t e;
    got_t g;
    send(1'b1, 2'd0, 1'b0, 48'h13, 64'h00000000000000AB, 1'b1, 1'b0);
    wait_drain();
    n_checks++;
    if (last_rd_addr !== 48'h10) begin
      n_fail++; $display("FAIL rmw_read_addr: addr=%h required 10", last_rd_addr);
    end
    n_checks++;
    if (last_wr_addr !== 48'h10 || last_wr_data !== 64'h11223344AB667788) begin
      n_fail++; $display("FAIL rmw_write: addr=%h data=%h required 10 / 11223344ab667788",
                         last_wr_addr, last_wr_data);
    end
    send(1'b0, 2'd2, 1'b0, 48'h10, 64'd0, 1'b1, 1'b0);
    send(1'b0, 2'd1, 1'b1, 48'h12, 64'd0, 1'b1, 1'b0);
    send(1'b1, 2'd2, 1'b0, 48'h14, 64'hDEADBEEF_CAFEF00D, 1'b1, 1'b0);
    send(1'b0, 2'd3, 1'b0, 48'h10, 64'd0, 1'b1, 1'b0);
    wait_drain();
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g.rdata !== e.rdata || g.mis !== e.mis || (g.cyc - e.acc + 1) != e.lat) begin
        n_fail++;
        $display("FAIL byte_rmw: rdata=%h mis=%b lat=%0d required rdata=%h mis=%b lat=%0d",
                 g.rdata, g.mis, g.cyc - e.acc + 1, e.rdata, e.mis, e.lat);
      end
    end
  endtask

  task automatic test_extension();
    exp_t e;
    got_t g;
    send(1'b1, 2'd3, 1'b0, 48'h20, 64'h000000000000F080, 1'b1, 1'b0);
    send(1'b0, 2'd0, 1'b0, 48'h20, 64'd0, 1'b1, 1'b0);
    send(1'b0, 2'd0, 1'b1, 48'h20, 64'd0, 1'b1, 1'b0);
    send(1'b0, 2'd1, 1'b0, 48'h20, 64'd0, 1'b1, 1'b0);
    send(1'b0, 2'd1, 1'b1, 48'h20, 64'd0, 1'b1, 1'b0);
    send(1'b0, 2'd0, 1'b0, 48'h21, 64'd0, 1'b1, 1'b0);
    send(1'b0, 2'd2, 1'b0, 48'h20, 64'd0, 1'b1, 1'b0);
    send(1'b0, 2'd3, 1'b1, 48'h20, 64'd0, 1'b1, 1'b0);
    wait_drain();
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g.rdata !== e.rdata || g.mis !== e.mis || (g.cyc - e.acc + 1) != e.lat) begin
        n_fail++;
        $display("FAIL extension: rdata=%h mis=%b lat=%0d required rdata=%h mis=%b lat=%0d",
                 g.rdata, g.mis, g.cyc - e.acc + 1, e.rdata, e.mis, e.lat);
      end
    end
  endtask

  task automatic test_misaligned();
    exp_t e;
    got_t g;
    int rd0;
    int wr0;
    rd0 = n_rd;
    wr0 = n_wr;
    send(1'b0, 2'd2, 1'b0, 48'h22, 64'd0, 1'b1, 1'b0);
    send(1'b1, 2'd1, 1'b0, 48'h31, 64'hBEEF, 1'b1, 1'b0);
    send(1'b1, 2'd3, 1'b0, 48'h14, 64'h5555, 1'b1, 1'b0);
    send(1'b0, 2'd3, 1'b1, 48'h1C, 64'd0, 1'b1, 1'b0);
    wait_drain();
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g.rdata !== e.rdata || g.mis !== e.mis || (g.cyc - e.acc + 1) != e.lat) begin
        n_fail++;
        $display("FAIL misaligned: rdata=%h mis=%b lat=%0d required rdata=%h mis=%b lat=%0d",
                 g.rdata, g.mis, g.cyc - e.acc + 1, e.rdata, e.mis, e.lat);
      end
    end
    n_checks++;
    if (n_rd != rd0 || n_wr != wr0) begin
      n_fail++; $display("FAIL misaligned_bus: reads=%0d writes=%0d required 0 0", n_rd - rd0, n_wr - wr0);
    end
  endtask

  task automatic test_reset_mid_rmw();
    exp_t e;
    got_t g;
    int wr0;
    logic [63:0] m;
    wr0 = n_wr;
    send(1'b1, 2'd1, 1'b0, 48'h30, 64'hBEEF, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_read, mem_write, resp_valid, resp_misaligned, req_ready} !== 5'b0 ||
        mem_address !== '0 || mem_wdata !== '0 || resp_rdata !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: rd=%b wr=%b rv=%b rdy=%b addr=%h wdata=%h required all 0",
               mem_read, mem_write, resp_valid, req_ready, mem_address, mem_wdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    m = mem.exists(45'h6) ? mem[45'h6] : 64'd0;
    n_checks++;
    if (n_wr != wr0 || m !== 64'd0) begin
      n_fail++; $display("FAIL midreset_memory: writes=%0d mem30=%h required 0 / 0", n_wr - wr0, m);
    end
    send(1'b0, 2'd1, 1'b1, 48'h30, 64'd0, 1'b1, 1'b0);
    send(1'b0, 2'd3, 1'b0, 48'h10, 64'd0, 1'b1, 1'b0);
    wait_drain();
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g.rdata !== e.rdata || g.mis !== e.mis || (g.cyc - e.acc + 1) != e.lat) begin
        n_fail++;
        $display("FAIL midreset_resume: rdata=%h mis=%b lat=%0d required rdata=%h mis=%b lat=%0d",
                 g.rdata, g.mis, g.cyc - e.acc + 1, e.rdata, e.mis, e.lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    got_t g;
    int lat;
    int popped;
    bit busy;
    logic [1:0] sz;
    logic [47:0] a;
    popped = 0;
    for (int i = 0; i < 12; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 48'h40 + 48'(8 * (i % 4)) + 48'($urandom_range(0, 7) & ~((1 << sz) - 1));
      send(1'(i % 2 == 0), sz, 1'($urandom()), a, {$urandom(), $urandom()}, 1'b1, 1'b1);
      lat = (exp_q.size() > 0) ? exp_q[$].lat : 1;
      busy = 1'b0;
      for (int k = 0; k < lat; k++) begin
        @(negedge clk);
        if (req_ready !== 1'b0) busy = 1'b1;
      end
      n_checks++;
      if (busy) begin
        n_fail++; $display("FAIL b2b_ready: req_ready high during request %0d, required low", i);
      end
    end
    req_valid = 1'b0;
    wait_drain();
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      popped++;
      n_checks++;
      if (g.rdata !== e.rdata || g.mis !== e.mis || (g.cyc - e.acc + 1) != e.lat) begin
        n_fail++;
        $display("FAIL b2b_resp: rdata=%h mis=%b lat=%0d required rdata=%h mis=%b lat=%0d",
                 g.rdata, g.mis, g.cyc - e.acc + 1, e.rdata, e.mis, e.lat);
      end
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (popped != 12 || got_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_count: responses=%0d extra=%0d required 12 / 0", popped, got_q.size());
    end
  endtask

  task automatic test_memory_image();
    logic [63:0] m;
    foreach (ref_mem[k]) begin
      m = mem.exists(k) ? mem[k] : 64'd0;
      n_checks++;
      if (m !== ref_mem[k]) begin
        n_fail++; $display("FAIL mem_image[%h]: got %h required %h", {k, 3'b000}, m, ref_mem[k]);
      end
    end
    n_checks++;
    if (n_both != 0 || exp_q.size() != 0 || got_q.size() != 0) begin
      n_fail++; $display("FAIL final_state: rd_wr_overlap=%0d pending=%0d extra=%0d required 0 0 0",
                         n_both, exp_q.size(), got_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_double_store_load();
    test_byte_rmw();
    test_extension();
    test_misaligned();
    test_reset_mid_rmw();
    test_back_to_back();
    test_memory_image();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
